// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_predictor_pkg : shared fetch/predictor constants and FSM enc. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package branch_predictor_pkg;

  localparam int DBITS          = 32;
  localparam int INSTSIZE       = 4;
  localparam int BRANCHPREDBITS = 4;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } bp_state_e;

endpackage
`default_nettype wire

// File: rtl/branch_predictor_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter : up/down counter clamped at 0 and all-ones, with load.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] loadval,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] c_max = '1;

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= loadval;
    end else if (inc && !dec && (r_count != c_max)) begin
      r_count <= r_count + WIDTH'(1);
    end else if (dec && !inc && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_predictor : direct-mapped BTB with 2-bit counters and stats.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int DBITS     = branch_predictor_pkg::DBITS,
  parameter int INDEXBITS = BRANCHPREDBITS,
  parameter int TAGBITS   = 8,
  parameter int CNTBITS   = 2,
  parameter int STATBITS  = 16,
  parameter int INSTSIZE  = branch_predictor_pkg::INSTSIZE
) (
  input  logic                clk,
  input  logic                RESET_N,
  input  logic                flush_req,
  input  logic [DBITS-1:0]    pc_F,
  output logic [DBITS-1:0]    pcpred_F,
  output logic                hit_F,
  input  logic                upd_valid,
  input  logic [DBITS-1:0]    upd_pc,
  input  logic                upd_isjump,
  input  logic                upd_taken,
  input  logic [DBITS-1:0]    upd_target,
  input  logic                upd_mispred,
  output logic                busy,
  output logic [STATBITS-1:0] stat_branches,
  output logic [STATBITS-1:0] stat_mispred
);

  localparam int                   c_entries  = 1 << INDEXBITS;
  localparam logic [CNTBITS-1:0]   c_cnt_max  = '1;
  localparam logic [CNTBITS-1:0]   c_cnt_weak = c_cnt_max ^ (c_cnt_max >> 1);
  localparam logic [INDEXBITS-1:0] c_last_idx = '1;

  logic                r_valid  [0:c_entries-1];
  logic [TAGBITS-1:0]  r_tag    [0:c_entries-1];
  logic [DBITS-1:0]    r_target [0:c_entries-1];
  logic [CNTBITS-1:0]  r_cnt    [0:c_entries-1];

  bp_state_e            r_state;
  bp_state_e            w_state_nxt;
  logic [INDEXBITS-1:0] r_clr_idx;
  logic [INDEXBITS-1:0] w_clr_idx_nxt;
  logic                 w_ready;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    if (flush_req) begin
      w_state_nxt   = ST_CLEAR;
      w_clr_idx_nxt = '0;
    end else if (r_state == ST_CLEAR) begin
      w_clr_idx_nxt = r_clr_idx + INDEXBITS'(1);
      if (r_clr_idx == c_last_idx) begin
        w_state_nxt = ST_READY;
      end
    end
  end

  assign w_ready = (r_state == ST_READY);
  assign busy    = !w_ready;

  // Fetch-side lookup reads the arrays before any same-cycle write lands.
  logic [INDEXBITS-1:0] w_f_idx;
  logic [TAGBITS-1:0]   w_f_tag;
  logic                 w_f_hit;

  assign w_f_idx  = pc_F[INDEXBITS+1:2];
  assign w_f_tag  = pc_F[INDEXBITS+TAGBITS+1:INDEXBITS+2];
  assign w_f_hit  = w_ready && r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign hit_F    = w_f_hit;
  assign pcpred_F = (w_f_hit && r_cnt[w_f_idx][CNTBITS-1]) ? r_target[w_f_idx]
                                                            : pc_F + DBITS'(INSTSIZE);

  logic [INDEXBITS-1:0] w_u_idx;
  logic [TAGBITS-1:0]   w_u_tag;
  logic                 w_u_hit;
  logic                 w_upd_ok;
  logic [CNTBITS-1:0]   w_cnt_old;
  logic [CNTBITS-1:0]   w_cnt_step;
  logic [CNTBITS-1:0]   w_cnt_new;
  logic                 w_wr_en;
  logic                 w_wr_target;
  logic                 w_unused_upd_pc;

  assign w_u_idx         = upd_pc[INDEXBITS+1:2];
  assign w_u_tag         = upd_pc[INDEXBITS+TAGBITS+1:INDEXBITS+2];
  assign w_u_hit         = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  assign w_upd_ok        = upd_valid && w_ready && !flush_req;
  assign w_cnt_old       = r_cnt[w_u_idx];
  assign w_unused_upd_pc = ^{upd_pc[1:0], upd_pc[DBITS-1:INDEXBITS+TAGBITS+2]};

  // Combinational twin of sat_counter for the per-entry confidence.
  always_comb begin
    w_cnt_step = w_cnt_old;
    if (upd_taken) begin
      if (w_cnt_old != c_cnt_max) w_cnt_step = w_cnt_old + CNTBITS'(1);
    end else begin
      if (w_cnt_old != '0) w_cnt_step = w_cnt_old - CNTBITS'(1);
    end
  end

  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_target = 1'b0;
    w_cnt_new   = w_cnt_old;
    if (w_upd_ok) begin
      if (upd_isjump) begin
        w_wr_en     = 1'b1;
        w_wr_target = 1'b1;
        w_cnt_new   = c_cnt_max;
      end else if (w_u_hit) begin
        w_wr_en     = 1'b1;
        w_wr_target = upd_taken;
        w_cnt_new   = w_cnt_step;
      end else if (upd_taken) begin
        w_wr_en     = 1'b1;
        w_wr_target = 1'b1;
        w_cnt_new   = c_cnt_weak;
      end
    end
  end

  // Entry storage has no reset; the CLEAR walk is the only invalidation path.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_valid[r_clr_idx] <= 1'b0;
    end else if (w_wr_en) begin
      r_valid[w_u_idx] <= 1'b1;
      r_tag[w_u_idx]   <= w_u_tag;
      r_cnt[w_u_idx]   <= w_cnt_new;
      if (w_wr_target) begin
        r_target[w_u_idx] <= upd_target;
      end
    end
  end

  sat_counter #(
    .WIDTH (STATBITS)
  ) u_stat_branches (
    .clk     (clk),
    .RESET_N (RESET_N),
    .inc     (w_upd_ok),
    .dec     (1'b0),
    .load    (flush_req),
    .loadval ({STATBITS{1'b0}}),
    .count   (stat_branches)
  );

  sat_counter #(
    .WIDTH (STATBITS)
  ) u_stat_mispred (
    .clk     (clk),
    .RESET_N (RESET_N),
    .inc     (w_upd_ok && upd_mispred),
    .dec     (1'b0),
    .load    (flush_req),
    .loadval ({STATBITS{1'b0}}),
    .count   (stat_mispred)
  );

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_branch_predictor : random + directed scoreboard bench.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_branch_predictor;

  localparam int DBITS    = 32;
  localparam int STATMAX  = 65535;
  localparam int NENT     = 16;

  logic        clk = 1'b0;
  logic        RESET_N = 1'b0;
  logic        flush_req = 1'b0;
  logic [31:0] pc_F = 32'h100;
  logic [31:0] pcpred_F;
  logic        hit_F;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_isjump = 1'b0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_mispred = 1'b0;
  logic        busy;
  logic [15:0] stat_branches;
  logic [15:0] stat_mispred;

  always #5 clk = ~clk;

  branch_predictor #(
    .DBITS(32), .INDEXBITS(4), .TAGBITS(8), .CNTBITS(2), .STATBITS(16), .INSTSIZE(4)
  ) dut (
    .clk(clk), .RESET_N(RESET_N), .flush_req(flush_req),
    .pc_F(pc_F), .pcpred_F(pcpred_F), .hit_F(hit_F),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_isjump(upd_isjump),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispred(upd_mispred),
    .busy(busy), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic [31:0] pred;
    logic        busy;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: a table of entries, a count of remaining clear cycles, plain ints for stats.
  bit          m_valid  [NENT];
  int          m_tag    [NENT];
  logic [31:0] m_target [NENT];
  int          m_cnt    [NENT];
  int          m_clear_left;
  int          m_sb, m_sm;

  function automatic void model_reset();
    for (int k = 0; k < NENT; k++) m_valid[k] = 1'b0;
    m_clear_left = NENT;
    m_sb = 0;
    m_sm = 0;
  endfunction

  function automatic void model_step(bit fl, bit uv, bit jump, bit taken, bit mis,
                                     logic [31:0] upc, logic [31:0] tgt);
    int  i, t;
    bit  h;
    if (fl) begin
      model_reset();
      return;
    end
    if (m_clear_left > 0) begin
      m_clear_left--;
      return;
    end
    if (!uv) return;
    if (m_sb < STATMAX) m_sb++;
    if (mis && m_sm < STATMAX) m_sm++;
    i = int'(upc[5:2]);
    t = int'(upc[13:6]);
    h = m_valid[i] && (m_tag[i] == t);
    if (jump || taken) begin
      if (jump)      m_cnt[i] = 3;
      else if (h)    m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
      else           m_cnt[i] = 2;
      m_valid[i]  = 1'b1;
      m_tag[i]    = t;
      m_target[i] = tgt;
    end else if (h) begin
      m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
    end
  endfunction

  task automatic drive(input bit rst_n_i, input bit fl, input bit uv, input bit jump,
                       input bit taken, input bit mis, input logic [31:0] upc,
                       input logic [31:0] tgt, input logic [31:0] pcf);
    exp_t e;
    int   i;
    @(posedge clk);
    #1;
    RESET_N     = rst_n_i;
    flush_req   = fl;
    upd_valid   = uv;
    upd_isjump  = jump;
    upd_taken   = taken;
    upd_mispred = mis;
    upd_pc      = upc;
    upd_target  = tgt;
    pc_F        = pcf;
    if (!rst_n_i) model_reset();
    i      = int'(pcf[5:2]);
    e.pc   = pcf;
    e.busy = (m_clear_left > 0);
    e.hit  = !e.busy && m_valid[i] && (m_tag[i] == int'(pcf[13:6]));
    e.pred = (e.hit && m_cnt[i] >= 2) ? m_target[i] : pcf + 32'd4;
    e.sb   = m_sb;
    e.sm   = m_sm;
    q.push_back(e);
    if (rst_n_i) model_step(fl, uv, jump, taken, mis, upc, tgt);
  endtask

  task automatic idle(input logic [31:0] pcf);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, pcf);
  endtask

  task automatic upd(input logic [31:0] upc, input bit jump, input bit taken,
                     input logic [31:0] tgt, input bit mis, input logic [31:0] pcf);
    drive(1'b1, 1'b0, 1'b1, jump, taken, mis, upc, tgt, pcf);
  endtask

  task automatic chk(input string name, input logic [31:0] pc, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s pc_F=%h actual=%h expected=%h t=%0t", name, pc, act, exp, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; sample mid-cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("hit_F",         e.pc, {31'b0, hit_F}, {31'b0, e.hit});
      chk("pcpred_F",      e.pc, pcpred_F,       e.pred);
      chk("busy",          e.pc, {31'b0, busy},  {31'b0, e.busy});
      chk("stat_branches", e.pc, {16'b0, stat_branches}, e.sb);
      chk("stat_mispred",  e.pc, {16'b0, stat_mispred},  e.sm);
    end
  end

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = {18'h0, 6'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00} + 32'h100;
    if ($urandom_range(0, 7) == 0) p = p | ($urandom() & 32'hFFFF_C000);
    return p;
  endfunction

  initial begin
    model_reset();
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h100);
    repeat (18) idle(32'h100);

    upd(32'h108, 1'b0, 1'b1, 32'h200, 1'b1, 32'h108);
    idle(32'h108);
    upd(32'h108, 1'b0, 1'b0, 32'h0, 1'b0, 32'h108);
    idle(32'h108);

    upd(32'h120, 1'b1, 1'b1, 32'h400, 1'b0, 32'h120);
    repeat (4) upd(32'h120, 1'b0, 1'b0, 32'h0, 1'b1, 32'h120);
    idle(32'h120);
    upd(32'h120, 1'b0, 1'b1, 32'h400, 1'b0, 32'h120);
    idle(32'h120);

    upd(32'h108, 1'b0, 1'b1, 32'h200, 1'b0, 32'h148);
    idle(32'h148);
    upd(32'h148, 1'b0, 1'b1, 32'h300, 1'b1, 32'h108);
    idle(32'h108);
    idle(32'h148);

    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h148, 32'h500, 32'h148);
    repeat (7) upd(32'h148, 1'b0, 1'b1, 32'h500, 1'b1, 32'h148);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h148);
    repeat (18) upd(32'h148, 1'b0, 1'b1, 32'h500, 1'b1, 32'h148);

    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h100);
    repeat (5) idle(32'h100);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h100);
    repeat (20) idle(32'h100);

    for (int n = 0; n < 3000; n++) begin
      bit rst_i, fl_i;
      rst_i = ($urandom_range(0, 399) != 0);
      fl_i  = ($urandom_range(0, 99) == 0);
      drive(rst_i, fl_i, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_pc(),
            $urandom() & 32'hFFFF_FFFC, rand_pc());
    end

    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h100);
    repeat (16) idle(32'h100);
    for (int n = 0; n < STATMAX + 3; n++)
      upd(rand_pc(), 1'b0, 1'($urandom_range(0, 1)), 32'h800, 1'b1, rand_pc());
    idle(32'hFFFF_FFFC);
    idle(32'h100);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d pending expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
